// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - button debounce and HH:MM:SS digit-edit sequencer for the clock counter
module clock_set_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mode_button,
    input  logic        i_inc_button,
    input  logic [23:0] i_current_time,
    output logic [23:0] o_set_time,
    output logic        o_load,
    output logic        o_setting,
    output logic [5:0]  o_digit_sel
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HT, S_HU, S_MT, S_MU, S_ST, S_SU, S_COMMIT
    } state_t;

    // Bit 0 is MODE, bit 1 is INC; raw keys are active-low.
    logic [1:0]      r_sync1, r_sync2, r_db, r_press;
    logic [DB_W-1:0] r_db_cnt [2];
    logic [1:0]      w_raw;

    assign w_raw = {i_inc_button, i_mode_button};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_db    <= 2'b11;
            r_press <= 2'b00;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                    r_press[i]  <= ~r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic w_mode_press, w_inc_press;
    assign w_mode_press = r_press[0];
    assign w_inc_press  = r_press[1];

    state_t          r_state, w_next;
    logic [TO_W-1:0] r_timeout;
    logic [23:0]     r_set_time, w_next_time;
    logic            w_in_set, w_timeout_hit, w_clamp;
    logic [5:0]      w_next_sel;

    assign w_in_set      = (r_state != S_IDLE) && (r_state != S_COMMIT);
    assign w_timeout_hit = (r_timeout == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_mode_press) w_next = S_HT;
            S_HT:     if (w_mode_press) w_next = S_HU;
            S_HU:     if (w_mode_press) w_next = S_MT;
            S_MT:     if (w_mode_press) w_next = S_MU;
            S_MU:     if (w_mode_press) w_next = S_ST;
            S_ST:     if (w_mode_press) w_next = S_SU;
            S_SU:     if (w_mode_press) w_next = S_COMMIT;
            default:  w_next = S_IDLE;
        endcase
        // A press in the same cycle restarts the idle count, so it beats the timeout.
        if (w_in_set && !w_mode_press && !w_inc_press && w_timeout_hit)
            w_next = S_IDLE;
    end

    always_comb begin
        w_next_time = r_set_time;
        w_clamp     = 1'b0;
        if (r_state == S_IDLE && w_mode_press) begin
            w_next_time = i_current_time;
            w_clamp     = 1'b1;
        end else if (w_in_set && !w_mode_press && w_inc_press) begin
            case (r_state)
                S_HT: begin
                    w_next_time[23:20] = (r_set_time[23:20] >= 4'd2) ? 4'd0 : r_set_time[23:20] + 4'd1;
                    w_clamp = 1'b1;
                end
                S_HU: if (r_set_time[23:20] == 4'd2)
                          w_next_time[19:16] = (r_set_time[19:16] >= 4'd3) ? 4'd0 : r_set_time[19:16] + 4'd1;
                      else
                          w_next_time[19:16] = (r_set_time[19:16] >= 4'd9) ? 4'd0 : r_set_time[19:16] + 4'd1;
                S_MT: w_next_time[15:12] = (r_set_time[15:12] >= 4'd5) ? 4'd0 : r_set_time[15:12] + 4'd1;
                S_MU: w_next_time[11:8]  = (r_set_time[11:8]  >= 4'd9) ? 4'd0 : r_set_time[11:8]  + 4'd1;
                S_ST: w_next_time[7:4]   = (r_set_time[7:4]   >= 4'd5) ? 4'd0 : r_set_time[7:4]   + 4'd1;
                default: w_next_time[3:0] = (r_set_time[3:0]  >= 4'd9) ? 4'd0 : r_set_time[3:0]   + 4'd1;
            endcase
        end
        if (w_clamp && w_next_time[23:20] == 4'd2 && w_next_time[19:16] > 4'd3)
            w_next_time[19:16] = 4'd3;
    end

    always_comb begin
        w_next_sel = 6'b000000;
        case (w_next)
            S_HT:    w_next_sel = 6'b100000;
            S_HU:    w_next_sel = 6'b010000;
            S_MT:    w_next_sel = 6'b001000;
            S_MU:    w_next_sel = 6'b000100;
            S_ST:    w_next_sel = 6'b000010;
            S_SU:    w_next_sel = 6'b000001;
            default: w_next_sel = 6'b000000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_timeout   <= '0;
            r_set_time  <= '0;
            o_load      <= 1'b0;
            o_setting   <= 1'b0;
            o_digit_sel <= '0;
        end else begin
            r_state     <= w_next;
            r_timeout   <= (!w_in_set || w_mode_press || w_inc_press) ? '0 : r_timeout + 1'b1;
            r_set_time  <= w_next_time;
            o_load      <= (w_next == S_COMMIT);
            o_setting   <= (w_next != S_IDLE) && (w_next != S_COMMIT);
            o_digit_sel <= w_next_sel;
        end
    end

    assign o_set_time = r_set_time;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - directed table and sequence bench for clock_set_controller
module tb_clock_set_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_btn = 1'b1;
    logic        inc_btn = 1'b1;
    logic [23:0] cur_time = 24'h000000;
    logic [23:0] set_time;
    logic        load, setting;
    logic [5:0]  digit_sel;

    int checks = 0;
    int failures = 0;
    int load_cnt = 0;

    clock_set_controller #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(200)) dut (
        .i_clk(clk), .i_rst(rst), .i_mode_button(mode_btn), .i_inc_button(inc_btn),
        .i_current_time(cur_time), .o_set_time(set_time), .o_load(load),
        .o_setting(setting), .o_digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load) load_cnt++;

    typedef struct {
        logic        is_inc;
        logic [23:0] cur;
        logic [23:0] exp_time;
        logic [5:0]  exp_sel;
        logic        exp_setting;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i);
        mode_btn = ~m;
        inc_btn  = ~i;
        wait_cycles(8);
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        wait_cycles(8);
    endtask

    task automatic check_outputs(input string name, input logic [23:0] t, input logic [5:0] s, input logic st);
        check({name, ".set_time"}, 32'(set_time), 32'(t));
        check({name, ".digit_sel"}, 32'(digit_sel), 32'(s));
        check({name, ".setting"}, 32'(setting), 32'(st));
    endtask

    initial begin
        int first;
        vecs[0]  = '{1'b0, 24'h195959, 24'h195959, 6'b100000, 1'b1};
        vecs[1]  = '{1'b1, 24'h195959, 24'h235959, 6'b100000, 1'b1};
        vecs[2]  = '{1'b0, 24'h195959, 24'h235959, 6'b010000, 1'b1};
        vecs[3]  = '{1'b1, 24'h195959, 24'h205959, 6'b010000, 1'b1};
        vecs[4]  = '{1'b0, 24'h195959, 24'h205959, 6'b001000, 1'b1};
        vecs[5]  = '{1'b1, 24'h195959, 24'h200959, 6'b001000, 1'b1};
        vecs[6]  = '{1'b0, 24'h195959, 24'h200959, 6'b000100, 1'b1};
        vecs[7]  = '{1'b1, 24'h195959, 24'h200059, 6'b000100, 1'b1};
        vecs[8]  = '{1'b0, 24'h195959, 24'h200059, 6'b000010, 1'b1};
        vecs[9]  = '{1'b1, 24'h195959, 24'h200009, 6'b000010, 1'b1};
        vecs[10] = '{1'b0, 24'h195959, 24'h200009, 6'b000001, 1'b1};
        vecs[11] = '{1'b1, 24'h195959, 24'h200000, 6'b000001, 1'b1};
        vecs[12] = '{1'b1, 24'h195959, 24'h200001, 6'b000001, 1'b1};
        vecs[13] = '{1'b0, 24'h195959, 24'h200001, 6'b000000, 1'b0};
        vecs[14] = '{1'b1, 24'h290000, 24'h200001, 6'b000000, 1'b0};
        vecs[15] = '{1'b0, 24'h290000, 24'h230000, 6'b100000, 1'b1};

        wait_cycles(3);
        check_outputs("reset", 24'h0, 6'b0, 1'b0);
        check("reset.load", 32'(load), 32'd0);
        rst = 1'b0;
        wait_cycles(2);

        // Bouncing MODE: only the final stable low may register, once.
        cur_time = 24'h123456;
        for (int k = 0; k < 5; k++) begin
            mode_btn = 1'b0; wait_cycles(2);
            mode_btn = 1'b1; wait_cycles(2);
        end
        check("bounce.no_early_press", 32'(setting), 32'd0);
        mode_btn = 1'b0;
        first = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (setting && first < 0) first = c;
        end
        checks++;
        if (first < 6 || first > 8) begin
            failures++;
            $display("FAIL bounce.latency: got %0d cycles expected 6..8", first);
        end
        check_outputs("bounce", 24'h123456, 6'b100000, 1'b1);
        mode_btn = 1'b1;
        wait_cycles(10);
        rst = 1'b1; wait_cycles(2); rst = 1'b0; wait_cycles(2);

        for (int v = 0; v < 16; v++) begin
            cur_time = vecs[v].cur;
            press(!vecs[v].is_inc, vecs[v].is_inc);
            check_outputs($sformatf("vec%0d", v), vecs[v].exp_time, vecs[v].exp_sel, vecs[v].exp_setting);
        end
        check("commit.load_count", 32'(load_cnt), 32'd1);

        // Reset while editing SET_MU discards the edit without loading.
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0);
        check("pre_reset.sel", 32'(digit_sel), 32'b000100);
        rst = 1'b1; wait_cycles(3);
        check_outputs("midreset", 24'h0, 6'b0, 1'b0);
        rst = 1'b0; wait_cycles(2);
        check_outputs("after_reset", 24'h0, 6'b0, 1'b0);
        check("midreset.load_count", 32'(load_cnt), 32'd1);
        cur_time = 24'h190000;
        press(1'b1, 1'b0);
        check_outputs("recapture", 24'h190000, 6'b100000, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check_outputs("hu_wrap_ht1", 24'h100000, 6'b010000, 1'b1);

        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check_outputs("simultaneous", 24'h100000, 6'b000100, 1'b1);

        press(1'b1, 1'b0);
        check("timeout.in_st", 32'(digit_sel), 32'b000010);
        wait_cycles(180);
        check("timeout.before", 32'(setting), 32'd1);
        wait_cycles(20);
        check_outputs("timeout.after", 24'h100000, 6'b0, 1'b0);
        check("timeout.load_count", 32'(load_cnt), 32'd1);

        for (int k = 0; k < 5; k++) press(1'b1, 1'b0);
        check_outputs("restart.in_st", 24'h190000, 6'b000010, 1'b1);
        wait_cycles(141);
        press(1'b0, 1'b1);
        wait_cycles(100);
        check_outputs("restart.still_set", 24'h190010, 6'b000010, 1'b1);
        wait_cycles(100);
        check_outputs("restart.timed_out", 24'h190010, 6'b0, 1'b0);
        check("restart.load_count", 32'(load_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
